p2s_loader: RTL and testbench

P2S_LOADER -- requirements
Module: p2s_loader

---
 rtl/p2s_pkg.sv | 21 ++
 rtl/p2s_loader_if.sv | 15 +
 rtl/p2s_refresh_timer.sv | 24 ++
 rtl/p2s_loader.sv | 132 +++++++++++++
 tb/tb_p2s_loader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/p2s_pkg.sv
// Shared types and constants for the p2s_loader block.
package p2s_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ACK,
    SHIFT,
    GAP
  } state_t;

  localparam int DEFAULT_DATA_BITS = 16;
  localparam int GAP_CYCLES        = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/p2s_loader_if.sv
// Upstream valid/ready word channel into p2s_loader.
interface p2s_loader_if
  import p2s_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/p2s_refresh_timer.sv
// Idle-interval counter with clear and terminal-count flag, used for automatic retransmit.
module p2s_refresh_timer #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CW'(1);
  end

  assign tc = (count == CW'(CYCLES - 1));

endmodule

// File: rtl/p2s_loader.sv
// Loads words into a parallel-to-serial shifter and sequences its start/ack/shift handshake.
// Optional automatic retransmit after an idle interval: define P2S_LOADER_REFRESH_EN.
module p2s_loader
  import p2s_pkg::*;
#(
  parameter int DATA_BITS      = DEFAULT_DATA_BITS,
  parameter int START_HOLD     = 2,
  parameter int ACK_TIMEOUT    = 8,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  p2s_loader_if.slave          up,
  input  logic                 p2s_en,
  output logic                 serial,
  output logic [DATA_BITS-1:0] p_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_MAX = max3(START_HOLD, ACK_TIMEOUT, GAP_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t               state, next_state;
  logic [CW-1:0]        cnt, cnt_next;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pend_full;
  logic                 take, set_err, done_next;
  logic                 refresh_tc;

  assign up.in_ready = !pend_full;
  assign busy        = (state != IDLE);

`ifdef P2S_LOADER_REFRESH_EN
  p2s_refresh_timer #(
    .CYCLES (REFRESH_CYCLES)
  ) u_refresh (
    .clk (clk),
    .rst (rst),
    .en  (state == IDLE),
    .clr (state != START && next_state == START),
    .tc  (refresh_tc)
  );
`else
  assign refresh_tc = 1'b0;
`endif

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    take       = 1'b0;
    set_err    = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (pend_full) begin
          take       = 1'b1;
          next_state = START;
        end else if (refresh_tc) begin
          next_state = START;  // resend the word already on p_data
        end
      end
      START: begin
        if (cnt == CW'(START_HOLD - 1)) begin
          cnt_next   = '0;
          next_state = ACK;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ACK: begin
        if (!p2s_en) begin
          cnt_next   = '0;
          next_state = SHIFT;
        end else if (cnt == CW'(ACK_TIMEOUT)) begin
          set_err    = 1'b1;
          cnt_next   = '0;
          next_state = GAP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (p2s_en) begin
          done_next  = 1'b1;
          next_state = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_next   = '0;
          next_state = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the pending word register is reset too, so an abandoned word can never reach p_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      serial    <= 1'b0;
      p_data    <= '0;
      pend_data <= '0;
      pend_full <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      serial <= (state == START);
      done   <= done_next;
      if (set_err) err <= 1'b1;
      if (take) begin
        p_data    <= pend_data;
        pend_full <= 1'b0;
      end else if (up.in_valid && up.in_ready) begin
        pend_data <= up.in_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_p2s_loader.sv
// Directed self-checking bench for p2s_loader; define P2S_LOADER_REFRESH_EN to add the refresh test.
module tb_p2s_loader;
  import p2s_pkg::*;

  logic        clk;
  logic        rst;
  logic        p2s_en;
  logic        serial;
  logic [15:0] p_data;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  p2s_loader_if #(.DATA_BITS(16)) up ();

  p2s_loader #(
    .DATA_BITS      (16),
    .START_HOLD     (2),
    .ACK_TIMEOUT    (8),
    .REFRESH_CYCLES (20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .up     (up),
    .p2s_en (p2s_en),
    .serial (serial),
    .p_data (p_data),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_serial"},   32'(serial),      32'h0);
    check({tag, "_p_data"},   32'(p_data),      32'h0);
    check({tag, "_busy"},     32'(busy),        32'h0);
    check({tag, "_done"},     32'(done),        32'h0);
    check({tag, "_err"},      32'(err),         32'h0);
    check({tag, "_in_ready"}, 32'(up.in_ready), 32'h1);
  endtask

  initial begin
    rst         = 1'b1;
    p2s_en      = 1'b1;
    up.in_valid = 1'b0;
    up.in_data  = '0;

    step();
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Frame 1: accept at edge N, start pulse, shifter handshake, second word queued.
    up.in_data  = 16'hA5C3;
    up.in_valid = 1'b1;
    check("f1_ready_idle", 32'(up.in_ready), 32'h1);
    step();                                             // N
    up.in_valid = 1'b0;
    check("f1_ready_full", 32'(up.in_ready), 32'h0);
    check("f1_serial_n",   32'(serial),      32'h0);
    step();                                             // N+1
    check("f1_serial_n1",  32'(serial),      32'h0);
    check("f1_p_data_n1",  32'(p_data),      32'hA5C3);
    check("f1_busy_n1",    32'(busy),        32'h1);
    check("f1_ready_n1",   32'(up.in_ready), 32'h1);
    step();                                             // N+2
    check("f1_serial_n2",  32'(serial),      32'h1);
    check("f1_p_data_n2",  32'(p_data),      32'hA5C3);
    step();                                             // N+3
    check("f1_serial_n3",  32'(serial),      32'h1);
    step();                                             // N+4
    check("f1_serial_n4",  32'(serial),      32'h0);
    check("f1_busy_n4",    32'(busy),        32'h1);
    p2s_en = 1'b0;
    step();                                             // N+5, SHIFT
    check("f1_done_n5",    32'(done),        32'h0);
    check("f1_err_n5",     32'(err),         32'h0);
    up.in_data  = 16'h1234;
    up.in_valid = 1'b1;
    check("f2_ready_shift", 32'(up.in_ready), 32'h1);
    step();                                             // N+6, second word taken
    up.in_valid = 1'b0;
    check("f2_ready_taken", 32'(up.in_ready), 32'h0);
    for (int i = 7; i <= 20; i++) begin
      step();
      check("f1_shift_ready",  32'(up.in_ready), 32'h0);
      check("f1_shift_done",   32'(done),        32'h0);
      check("f1_shift_p_data", 32'(p_data),      32'hA5C3);
    end
    p2s_en = 1'b1;
    step();                                             // N+21
    check("f1_done_pulse", 32'(done),        32'h1);
    check("f1_busy_gap",   32'(busy),        32'h1);
    check("f1_p_data_gap", 32'(p_data),      32'hA5C3);
    step();                                             // N+22
    check("f1_done_once",  32'(done),        32'h0);
    check("f1_serial_gap", 32'(serial),      32'h0);
    check("f1_busy_gap2",  32'(busy),        32'h1);
    step();                                             // N+23, IDLE
    check("f1_busy_idle",  32'(busy),        32'h0);
    check("f2_ready_idle", 32'(up.in_ready), 32'h0);
    check("f2_p_data_old", 32'(p_data),      32'hA5C3);
    step();                                             // N+24, START of frame 2
    check("f2_busy",       32'(busy),        32'h1);
    check("f2_p_data",     32'(p_data),      32'h1234);
    check("f2_ready_free", 32'(up.in_ready), 32'h1);
    check("f2_serial_lo",  32'(serial),      32'h0);

    // Frame 2: shifter never acknowledges -> timeout.
    step();                                             // S, serial rises
    check("to_serial_rise", 32'(serial), 32'h1);
    for (int i = 1; i <= 9; i++) begin
      step();
      check("to_err_early", 32'(err),  32'h0);
      check("to_no_done",   32'(done), 32'h0);
    end
    step();                                             // S+10
    check("to_err_set",   32'(err),  32'h1);
    check("to_busy_gap",  32'(busy), 32'h1);
    check("to_serial_lo", 32'(serial), 32'h0);
    step();
    step();                                             // S+12, IDLE
    check("to_busy_idle", 32'(busy), 32'h0);
    repeat (4) step();
    check("to_err_sticky", 32'(err),  32'h1);
    check("to_busy_stay",  32'(busy), 32'h0);
    #2 rst = 1'b1;
    #1 check("to_err_cleared", 32'(err), 32'h0);
    step();
    rst = 1'b0;
    step();

    // Frame 3: reset during SHIFT with a word pending.
    up.in_data  = 16'hBEEF;
    up.in_valid = 1'b1;
    step();                                             // E
    up.in_valid = 1'b0;
    step();                                             // E+1
    step();                                             // E+2
    check("rs_serial_rise", 32'(serial), 32'h1);
    step();                                             // E+3
    p2s_en = 1'b0;
    step();                                             // E+4, SHIFT
    up.in_data  = 16'h5555;
    up.in_valid = 1'b1;
    step();                                             // E+5
    up.in_valid = 1'b0;
    check("rs_ready_full", 32'(up.in_ready), 32'h0);
    check("rs_busy",       32'(busy),        32'h1);
    check("rs_p_data",     32'(p_data),      32'hBEEF);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rs_async");
    step();
    rst    = 1'b0;
    p2s_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rs_no_done",   32'(done),        32'h0);
      check("rs_idle",      32'(busy),        32'h0);
      check("rs_serial",    32'(serial),      32'h0);
      check("rs_discarded", 32'(up.in_ready), 32'h1);
    end

`ifdef P2S_LOADER_REFRESH_EN
    // Frame 4: quick handshake, then idle until the refresh fires.
    up.in_data  = 16'hC0DE;
    up.in_valid = 1'b1;
    step();                                             // E
    up.in_valid = 1'b0;
    step();                                             // E+1
    step();                                             // E+2
    check("rf_serial_rise", 32'(serial), 32'h1);
    step();                                             // E+3
    p2s_en = 1'b0;
    step();                                             // E+4
    p2s_en = 1'b1;
    step();                                             // E+5
    check("rf_done", 32'(done), 32'h1);
    step();
    step();                                             // E+7 = G, IDLE
    check("rf_idle", 32'(busy), 32'h0);
    for (int i = 1; i <= 19; i++) begin
      step();
      check("rf_wait_busy",   32'(busy),   32'h0);
      check("rf_wait_serial", 32'(serial), 32'h0);
    end
    step();                                             // G+20, START
    check("rf_start_busy",   32'(busy),   32'h1);
    check("rf_start_serial", 32'(serial), 32'h0);
    step();                                             // G+21
    check("rf_serial_again", 32'(serial), 32'h1);
    check("rf_p_data_same",  32'(p_data), 32'hC0DE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
